// File: rtl/ripple_mon_pkg.sv
// Shared types and helpers for the ripple-counter monitor.
// State encoding, default widths and the bit-order reversal used on the raw counter bus.
package ripple_mon_pkg;

  localparam int DEF_WIDTH     = 3;
  localparam int DEF_EXT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_e;

  // Reverses the low w bits of v; bits at w and above come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ripple_count_monitor_if.sv
// Signal bundle between the ripple-counter monitor and its surroundings.
// master drives enable, raw count, compare value and clear; slave returns the clean view.
interface ripple_count_monitor_if
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXT_WIDTH = DEF_EXT_WIDTH
);

  logic                 en;
  logic [WIDTH-1:0]     cnt_in;
  logic [WIDTH-1:0]     match_val;
  logic                 clr_wrap;
  logic [WIDTH-1:0]     count_sync;
  logic                 wrap_pulse;
  logic                 match_pulse;
  logic [EXT_WIDTH-1:0] wrap_count;
  logic                 wrap_ovf;
  logic                 err_skip;

  modport master (
    output en, cnt_in, match_val, clr_wrap,
    input  count_sync, wrap_pulse, match_pulse, wrap_count, wrap_ovf, err_skip
  );

  modport slave (
    input  en, cnt_in, match_val, clr_wrap,
    output count_sync, wrap_pulse, match_pulse, wrap_count, wrap_ovf, err_skip
  );

endinterface

// File: rtl/ripple_sync_filter.sv
// Synchronises the rippling counter bus and accepts only values stable for two sampled cycles.
// Latency: 3 edges from a stable input to the accept strobe; no backpressure, free-running.
module ripple_sync_filter
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int BIT_REVERSE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             acc_vld_o,
  output logic [WIDTH-1:0] acc_dat_o
);

  logic [WIDTH-1:0] ord;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [2:0]       fill_q;

  if (BIT_REVERSE != 0) begin : g_rev
    assign ord = WIDTH'(bit_rev(32'(cnt_i), WIDTH));
  end else begin : g_norev
    assign ord = cnt_i;
  end

  // fill_q keeps the reset-zero contents of s1..s3 from being taken as a real sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      fill_q <= '0;
    end else begin
      s1_q   <= ord;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  assign acc_vld_o = fill_q[2] && (s2_q == s3_q);
  assign acc_dat_o = s3_q;

endmodule

// File: rtl/ripple_count_monitor.sv
// Clean synchronous view of a 3-bit ripple counter: filtered count, wrap/match pulses, wrap extension.
// Latency: 4 edges from a stable raw count to count_sync and pulses; no backpressure.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int BIT_REVERSE = 1,
  parameter int EXT_WIDTH   = DEF_EXT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  ripple_count_monitor_if.slave  bus
);

  logic                 acc_vld;
  logic [WIDTH-1:0]     acc_dat;
  logic [WIDTH-1:0]     delta;
  logic [EXT_WIDTH:0]   wc_inc;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic                 match_pulse_q, match_pulse_d;
  logic [EXT_WIDTH-1:0] wc_q, wc_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;

  ripple_sync_filter #(
    .WIDTH       (WIDTH),
    .BIT_REVERSE (BIT_REVERSE)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .cnt_i     (bus.cnt_in),
    .acc_vld_o (acc_vld),
    .acc_dat_o (acc_dat)
  );

  assign delta  = acc_dat - count_q;
  assign wc_inc = {1'b0, wc_q} + {{EXT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wrap_pulse_d  = 1'b0;
    match_pulse_d = 1'b0;
    wc_d          = wc_q;
    ovf_d         = ovf_q;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (acc_vld) begin
          count_d = acc_dat;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (acc_vld && (acc_dat != count_q)) begin
          count_d = acc_dat;
          if (delta != WIDTH'(1)) err_d = 1'b1;
          if (acc_dat < count_q) begin
            wrap_pulse_d = 1'b1;
            wc_d         = wc_inc[EXT_WIDTH-1:0];
            if (wc_inc[EXT_WIDTH]) ovf_d = 1'b1;
          end
          if (acc_dat == bus.match_val) match_pulse_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides any same-cycle increment or flag; wrap_pulse is left alone.
    if (bus.clr_wrap) begin
      wc_d  = '0;
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wrap_pulse_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      wc_q          <= '0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wrap_pulse_q  <= wrap_pulse_d;
      match_pulse_q <= match_pulse_d;
      wc_q          <= wc_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
    end
  end

  assign bus.count_sync  = count_q;
  assign bus.wrap_pulse  = wrap_pulse_q;
  assign bus.match_pulse = match_pulse_q;
  assign bus.wrap_count  = wc_q;
  assign bus.wrap_ovf    = ovf_q;
  assign bus.err_skip    = err_q;

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit JK ripple up-counter.
- Brings the counter's asynchronously rippling output into the `clk` domain and rejects ripple glitches with a stability filter.
- Tracks the filtered count and flags wrap-around (7->0), compare matches and skipped counts.
- Extends the count range with a wrap counter, giving the rest of the design a clean synchronous view of the ripple counter.

Parameters:
- WIDTH, 3: width of `cnt_in`, `match_val` and `count_sync`.
- BIT_REVERSE, 1: 1 = `cnt_in[WIDTH-1]` is the upstream fastest-toggling stage (LSB), so bits are reversed before use; 0 = `cnt_in` is already LSB-first.
- EXT_WIDTH, 8: width of `wrap_count`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  monitor enable.
- cnt_in  input  WIDTH  raw ripple-counter output; asynchronous to `clk`.
- match_val  input  WIDTH  compare value, quasi-static.
- clr_wrap  input  1  synchronous clear of `wrap_count`, `wrap_ovf` and `err_skip`.
- count_sync  output  WIDTH  filtered, LSB-first count.
- wrap_pulse  output  1  one-cycle pulse on each counted wrap.
- match_pulse  output  1  one-cycle pulse when `count_sync` changes to `match_val`.
- wrap_count  output  EXT_WIDTH  number of wraps seen.
- wrap_ovf  output  1  sticky; `wrap_count` rolled over.
- err_skip  output  1  sticky; accepted step was not +1.

Behaviour:
- Reset: `rst`=0 asynchronously forces state IDLE and all of the following to 0:
  - outputs: `count_sync`, `wrap_pulse`, `match_pulse`, `wrap_count`, `wrap_ovf`, `err_skip`;
  - internal sync/filter registers.
- Reset mid-operation aborts tracking; after release the block re-arms and pulses nothing until a new baseline is loaded.
- Input path:
  - reorder per BIT_REVERSE;
  - 2-flop synchroniser (s1, s2), then delay register s3;
  - "accepted" value = s3 when s2==s3, i.e. a value held stable for 2 consecutive cycles;
  - accepted value = `cnt_in` held stable since rising edge 1, registered into `count_sync` at edge 4 (4-cycle latency);
  - shorter stable intervals (ripple transients) are never accepted.
- FSM:
  - IDLE: no updates. Go to ARMED when `en`=1.
  - ARMED: first accepted value loads `count_sync`, no pulses or flags; go to TRACK.
  - TRACK: on each accepted value `new` != `count_sync` (`old`):
    - `count_sync` <= `new`;
    - delta = (new - old) mod 2^WIDTH;
    - delta != 1 sets `err_skip`;
    - new < old (unsigned) is a wrap: `wrap_pulse`=1 for one cycle, `wrap_count`+1;
    - `new` == `match_val` gives `match_pulse`=1 for one cycle.
  - `en`=0 in ARMED or TRACK -> IDLE next edge; `count_sync` holds, pulses forced 0.
- Pulse timing: both pulses assert in the same cycle `count_sync` takes the new value.
- `wrap_count` at all ones + wrap: rolls to 0 and sets `wrap_ovf`.
- `clr_wrap` (any state): next edge `wrap_count`=0, `wrap_ovf`=0, `err_skip`=0.
  - If a wrap coincides with `clr_wrap`: clear wins (`wrap_count`=0, no increment, `wrap_ovf` not set), but `wrap_pulse` still asserts.
  - If a skip coincides with `clr_wrap`: `err_skip` ends at 0.
- Accepted value equal to `count_sync`: no action.
- `match_val` equal to the baseline loaded in ARMED: no pulse.

Decomposition:
- Package `ripple_mon_pkg`:
  - state enum {IDLE, ARMED, TRACK};
  - bit-reverse function;
  - default WIDTH/EXT_WIDTH constants.
- One sub-module, `ripple_sync_filter`: reorder, s1/s2/s3 and the accept strobe plus value; parameterised by WIDTH and BIT_REVERSE.
- FSM, compare and wrap logic stay in the top module.

Test Plan:
- Reset/arm: `rst`=0 then 1, `en`=1, `cnt_in`=3'b000 held -> all outputs 0; after edge 4 state TRACK, `count_sync`=0, no pulses.
- Counting and wrap:
  - BIT_REVERSE=1, drive LSB-first values 1..7, 0 (bits reversed on `cnt_in`), each held 6 cycles -> `count_sync` follows with 4-cycle latency;
  - `wrap_pulse` exactly once on 7->0, `wrap_count`=1, `err_skip`=0.
- Glitch rejection: from count 3 drive transient 3->2->0->4, intermediate values 1 cycle each, then hold 4 -> `count_sync` goes 3->4 directly; no `err_skip`, no `match_pulse` with `match_val`=2.
- Skip: from count 2, `cnt_in` jumps and holds 5 -> `err_skip`=1 sticky; no wrap. From count 6, jump to 1 -> `wrap_pulse`, `wrap_count`+1.
- Overflow/clear:
  - EXT_WIDTH=2, 4 wraps -> `wrap_count`=0, `wrap_ovf`=1;
  - `clr_wrap` coinciding with a 5th wrap -> `wrap_pulse`=1, `wrap_count`=0, `wrap_ovf`=0.
- Match/enable/reset:
  - `match_val`=5, count 4->5 -> one `match_pulse`;
  - `en`=0 mid-run -> `count_sync` frozen, no pulses;
  - `rst`=0 while in TRACK -> immediate zeros; after `rst` release with `en` held 1, block re-arms to the held value with no pulses.
